// File: rtl/mem_io_responder.sv
// Data-side bus responder: turns MEM stage MREQ/IORQ requests into SRAM or I/O
// port cycles with per-target wait states, and stalls the MEM latch via D_wait.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no access in flight; a request latches address/data/kind/dir
// ACCESS | bus cycle active; counts down wait states, final cycle strobes
// DONE   | access complete, D_wait low so the MEM latch captures; -> IDLE
module mem_io_responder #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] D_addr,
  input  logic [7:0]  D_data_out,
  input  logic        IORQ,
  input  logic        MREQ,
  input  logic        RD,
  input  logic        WR,
  output logic [7:0]  D_data_in,
  output logic        D_wait,
  output logic [15:0] sram_addr,
  output logic [7:0]  sram_dout,
  input  logic [7:0]  sram_din,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_rd,
  output logic        io_wr,
  input  logic [7:0]  io_rdata,
  output logic        bus_err
);

  localparam logic [3:0] MEM_CNT = 4'(MEM_WAIT);
  localparam logic [3:0] IO_CNT  = 4'(IO_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       is_io, is_wr;
  logic       req;
  logic       start;
  logic       active;
  logic       last;

  assign req    = IORQ | MREQ;
  assign active = (state == ST_ACCESS) && req;
  assign last   = active && (cnt == 4'd0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          start     = 1'b1;
          cnt_nxt   = IORQ ? IO_CNT : MEM_CNT;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A dropped request is a pipeline flush: abandon without strobing.
        if (!req) begin
          cnt_nxt   = 4'd0;
          state_nxt = ST_IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        cnt_nxt   = 4'd0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request attributes are latched once; later input changes are ignored.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sram_addr <= 16'h0000;
      sram_dout <= 8'h00;
      io_addr   <= 8'h00;
      io_wdata  <= 8'h00;
      is_io     <= 1'b0;
      is_wr     <= 1'b0;
      bus_err   <= 1'b0;
    end else if (start) begin
      sram_addr <= D_addr;
      sram_dout <= D_data_out;
      io_addr   <= D_addr[7:0];
      io_wdata  <= D_data_out;
      is_io     <= IORQ;
      is_wr     <= WR;
      bus_err   <= bus_err | (IORQ & MREQ) | (RD == WR);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      D_data_in <= 8'h00;
    end else if (last && !is_wr) begin
      D_data_in <= is_io ? io_rdata : sram_din;
    end
  end

  // Strobes decode from state so an async reset releases them immediately.
  always_comb begin
    sram_ce_n = ~(active && !is_io);
    sram_oe_n = ~(active && !is_io && !is_wr);
    sram_we_n = ~(last && !is_io && is_wr);
    io_rd     = last && is_io && !is_wr;
    io_wr     = last && is_io && is_wr;
    D_wait    = RST && req && (state != ST_DONE);
  end

endmodule
